// File: rtl/ram2_arbiter.sv
// ram2_arbiter: shares the ram2 scratch RAM between two Avalon-MM masters.
// Per-cycle round-robin grant, waitrequest back-pressure, and per-port
// readdatavalid generated by a shift register matching the RAM read latency.
module ram2_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (JTAG-to-Avalon)
  input  logic [31:0]       m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1 (regfile-driven control)
  input  logic [31:0]       m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // shared RAM side
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  // Per-port request vectors, index 0 = m0, index 1 = m1.
  logic [1:0] read_vec;
  logic [1:0] write_vec;
  logic [1:0] req_vec;
  logic [1:0] grant;
  logic [1:0] rd_load;
  logic [1:0] rd_valid;

  // Port that most recently won; 1 out of reset so m0 wins first contention.
  logic last_grant_reg;
  logic last_grant_next;

  // Select for the shared address/data mux.
  logic sel;

  // Byte-address bits outside the word index are deliberately ignored.
  logic unused_addr_bits;

  assign read_vec  = {m1_read, m0_read};
  assign write_vec = {m1_write, m0_write};
  assign req_vec   = read_vec | write_vec;

  assign unused_addr_bits = ^{m0_address[31:ADDR_W+2], m0_address[1:0],
                              m1_address[31:ADDR_W+2], m1_address[1:0]};

  // Round-robin grant; nothing is granted while reset is held.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      unique case (req_vec)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Remember the granted port; hold when no access is granted.
  always_comb begin
    last_grant_next = last_grant_reg;
    if (grant[0]) begin
      last_grant_next = 1'b0;
    end else if (grant[1]) begin
      last_grant_next = 1'b1;
    end
  end

  // last_grant state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // Granted port drives the RAM; with no grant the last winner keeps the mux.
  always_comb begin
    sel = last_grant_reg;
    if (grant[1]) begin
      sel = 1'b1;
    end else if (grant[0]) begin
      sel = 1'b0;
    end
  end

  assign ram_address = sel ? m1_address[ADDR_W+1:2] : m0_address[ADDR_W+1:2];
  assign ram_data    = sel ? m1_writedata : m0_writedata;
  assign ram_wren    = |(grant & write_vec);

  assign m0_waitrequest = req_vec[0] & ~grant[0];
  assign m1_waitrequest = req_vec[1] & ~grant[1];

  // Read data goes to both ports; readdatavalid tells each master it is theirs.
  assign m0_readdata = ram_q;
  assign m1_readdata = ram_q;

  // A simultaneous read+write is treated as a write only: no read is tracked.
  assign rd_load = grant & read_vec & ~write_vec;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_track
      logic [RD_LAT-1:0] rd_pipe_reg;
      logic [RD_LAT-1:0] rd_pipe_next;

      if (RD_LAT == 1) begin : g_lat1
        // Single-stage latency: the load bit is the whole pipeline.
        always_comb begin
          rd_pipe_next = rd_load[gi];
        end
      end else begin : g_latn
        // Shift accepted reads toward the valid stage in acceptance order.
        always_comb begin
          rd_pipe_next = {rd_pipe_reg[RD_LAT-2:0], rd_load[gi]};
        end
      end

      // Read-tracking shift register; reset discards in-flight reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_pipe_reg <= '0;
        end else begin
          rd_pipe_reg <= rd_pipe_next;
        end
      end

      assign rd_valid[gi] = rd_pipe_reg[RD_LAT-1];
    end
  endgenerate

  assign m0_readdatavalid = rd_valid[0];
  assign m1_readdatavalid = rd_valid[1];

endmodule

// File: tb/tb_ram2_arbiter.sv
// tb_ram2_arbiter: table vectors, directed corner sequences and randomized
// traffic, all scored against a transaction-level model of the arbiter.
module tb_ram2_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       m0_address = '0;
  logic              m0_read = 1'b0;
  logic              m0_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;
  logic [31:0]       m1_address = '0;
  logic              m1_read = 1'b0;
  logic              m1_write = 1'b0;
  logic [DATA_W-1:0] m1_writedata = '0;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q = '0;

  ram2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Stand-in for ram2: write at the edge, read data two edges later.
  logic [DATA_W-1:0] tb_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] q_stage = '0;
  always @(posedge clk) begin
    if (ram_wren) tb_mem[ram_address] <= ram_data;
    q_stage <= tb_mem[ram_address];
    ram_q   <= q_stage;
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct { int due; logic [31:0] data; } pend_t;
  pend_t       pq0[$];
  pend_t       pq1[$];
  logic [31:0] shadow [DEPTH];
  int          mdl_last = 1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  // Observations of the most recent cycle, for directed checks.
  logic        obs_wait [2];
  logic        obs_valid [2];
  logic [31:0] obs_data [2];
  logic        obs_wren;
  logic [4:0]  obs_addr;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = data;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = data;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One cycle: inputs already applied at the falling edge. Checks every
  // output against the model, then commits accepted accesses.
  task automatic step();
    logic        r [2];
    logic        w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    int          g;
    int          s;
    logic        ev;
    logic [31:0] ed;
    pend_t       e;
    logic [4:0]  wd;
    #1;
    r[0] = m0_read;  w[0] = m0_write;  a[0] = m0_address; d[0] = m0_writedata;
    r[1] = m1_read;  w[1] = m1_write;  a[1] = m1_address; d[1] = m1_writedata;
    if (rst) begin
      g = -1;
      pq0.delete();
      pq1.delete();
      mdl_last = 1;
    end else if ((r[0] | w[0]) && (r[1] | w[1])) begin
      g = (mdl_last == 1) ? 0 : 1;
    end else if (r[0] | w[0]) begin
      g = 0;
    end else if (r[1] | w[1]) begin
      g = 1;
    end else begin
      g = -1;
    end
    obs_wait[0] = m0_waitrequest;   obs_wait[1] = m1_waitrequest;
    obs_valid[0] = m0_readdatavalid; obs_valid[1] = m1_readdatavalid;
    obs_data[0] = m0_readdata;      obs_data[1] = m1_readdata;
    obs_wren = ram_wren;            obs_addr = ram_address;

    check1("m0_waitrequest", m0_waitrequest, (r[0] | w[0]) && (g != 0));
    check1("m1_waitrequest", m1_waitrequest, (r[1] | w[1]) && (g != 1));
    check1("ram_wren", ram_wren, (g >= 0) ? w[g] : 1'b0);
    s = (g >= 0) ? g : mdl_last;
    check32("ram_address", 32'(ram_address), 32'(a[s][6:2]));
    if (g >= 0 && w[g]) check32("ram_data", ram_data, d[g]);

    ev = 1'b0; ed = '0;
    if (pq0.size() > 0 && pq0[0].due == cyc) begin
      ev = 1'b1; ed = pq0[0].data; pq0.delete(0);
    end
    check1("m0_readdatavalid", m0_readdatavalid, ev);
    if (ev) check32("m0_readdata", m0_readdata, ed);
    ev = 1'b0; ed = '0;
    if (pq1.size() > 0 && pq1[0].due == cyc) begin
      ev = 1'b1; ed = pq1[0].data; pq1.delete(0);
    end
    check1("m1_readdatavalid", m1_readdatavalid, ev);
    if (ev) check32("m1_readdata", m1_readdata, ed);

    if (g >= 0) begin
      wd = a[g][6:2];
      if (w[g]) begin
        shadow[wd] = d[g];
      end else if (r[g]) begin
        e.due = cyc + RD_LAT;
        e.data = shadow[wd];
        if (g == 0) pq0.push_back(e); else pq1.push_back(e);
      end
      mdl_last = g;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    idle_all();
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  // Applied one per cycle from a fresh reset: {r0 w0 r1 w1 | ew0 ew1 ewren | eaddr}
  typedef struct packed {
    logic r0, w0, r1, w1, ew0, ew1, ewren;
    logic [4:0] eaddr;
  } vec_t;
  vec_t tbl [9];

  int          idx [2];
  int          got [2];
  int          gprev;
  int          gnow;
  int          guard;
  logic        busy [2];
  logic        prd [2];
  logic        pwr [2];
  logic [31:0] pad [2];
  logic [31:0] pdt [2];

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    tbl[0] = {7'b1010010, 5'd5};
    tbl[1] = {7'b1010100, 5'd11};
    tbl[2] = {7'b0100001, 5'd5};
    tbl[3] = {7'b0001001, 5'd11};
    tbl[4] = {7'b0000000, 5'd11};
    tbl[5] = {7'b0101011, 5'd5};
    tbl[6] = {7'b1001101, 5'd11};
    tbl[7] = {7'b0011001, 5'd11};
    tbl[8] = {7'b1010010, 5'd5};

    @(negedge clk);
    do_reset(2);

    // Table: arbitration sequence starting from reset (m0 wins first).
    for (int i = 0; i < 9; i++) begin
      drive(0, tbl[i].r0, tbl[i].w0, 32'h14, 32'h0000_00A0 + i);
      drive(1, tbl[i].r1, tbl[i].w1, 32'h2C, 32'h0000_00B0 + i);
      step();
      check1($sformatf("tbl_wait0[%0d]", i), obs_wait[0], tbl[i].ew0);
      check1($sformatf("tbl_wait1[%0d]", i), obs_wait[1], tbl[i].ew1);
      check1($sformatf("tbl_wren[%0d]", i), obs_wren, tbl[i].ewren);
      check32($sformatf("tbl_addr[%0d]", i), 32'(obs_addr), 32'(tbl[i].eaddr));
    end
    idle_all();
    repeat (3) step();

    // Single port: write then read word 5, m1 idle.
    drive(0, 1'b0, 1'b1, 32'h14, 32'hDEAD_BEEF);
    step();
    check1("sp_wr_wait", obs_wait[0], 1'b0);
    drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
    step();
    check1("sp_rd_wait", obs_wait[0], 1'b0);
    idle_all();
    step();
    check1("sp_valid_early", obs_valid[0], 1'b0);
    step();
    check1("sp_valid", obs_valid[0], 1'b1);
    check32("sp_data", obs_data[0], 32'hDEAD_BEEF);
    check1("sp_m1_valid", obs_valid[1], 1'b0);
    step();

    // Contention straight out of reset.
    drive(1, 1'b0, 1'b1, 32'h2C, 32'h1111_2222);
    step();
    do_reset(2);
    drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h2C, 32'h0);
    step();
    check1("ct_wait0", obs_wait[0], 1'b0);
    check1("ct_wait1", obs_wait[1], 1'b1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check1("ct_wait1_next", obs_wait[1], 1'b0);
    idle_all();
    step();
    check1("ct_valid0", obs_valid[0], 1'b1);
    check32("ct_data0", obs_data[0], 32'hDEAD_BEEF);
    check1("ct_valid1_early", obs_valid[1], 1'b0);
    step();
    check1("ct_valid1", obs_valid[1], 1'b1);
    check32("ct_data1", obs_data[1], 32'h1111_2222);
    step();

    // Sustained contention: preload words 0..7, then 8 reads per port.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b0, 1'b1, 32'(i * 4), 32'(i));
      step();
    end
    idx[0] = 0; idx[1] = 0; got[0] = 0; got[1] = 0;
    gprev = -1; guard = 0;
    while ((got[0] < 8 || got[1] < 8) && guard < 60) begin
      for (int p = 0; p < 2; p++) begin
        if (idx[p] < 8) drive(p, 1'b1, 1'b0, 32'(idx[p] * 4), 32'h0);
        else            drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      step();
      for (int p = 0; p < 2; p++) begin
        if (obs_valid[p]) begin
          check32($sformatf("sus_data_m%0d", p), obs_data[p], 32'(got[p]));
          got[p]++;
        end
      end
      gnow = -1;
      for (int p = 0; p < 2; p++) if (idx[p] < 8 && !obs_wait[p]) gnow = p;
      if (gnow >= 0) begin
        if (gprev >= 0) checki("sus_alternate", gnow, 1 - gprev);
        gprev = gnow;
        idx[gnow]++;
      end
      guard++;
    end
    checki("sus_count_m0", got[0], 8);
    checki("sus_count_m1", got[1], 8);
    idle_all();
    step();

    // Address wrap: byte 0x80 aliases word 0.
    drive(0, 1'b0, 1'b1, 32'h80, 32'hCAFE_0080);
    step();
    drive(0, 1'b1, 1'b0, 32'h00, 32'h0);
    step();
    idle_all();
    step();
    step();
    check1("wrap_valid", obs_valid[0], 1'b1);
    check32("wrap_data", obs_data[0], 32'hCAFE_0080);

    // Protocol error: read+write together acts as a write with no return.
    drive(1, 1'b1, 1'b1, 32'h0C, 32'h5A5A_5A5A);
    step();
    check1("perr_wren", obs_wren, 1'b1);
    idle_all();
    for (int i = 0; i < 3; i++) begin
      step();
      check1("perr_no_valid", obs_valid[1], 1'b0);
    end
    drive(1, 1'b1, 1'b0, 32'h0C, 32'h0);
    step();
    idle_all();
    step();
    step();
    check1("perr_rd_valid", obs_valid[1], 1'b1);
    check32("perr_word3", obs_data[1], 32'h5A5A_5A5A);

    // Reset one cycle after an accepted read drops it.
    drive(0, 1'b1, 1'b0, 32'h00, 32'h0);
    step();
    idle_all();
    rst = 1'b1;
    step();
    check1("rmr_valid_rst0", obs_valid[0], 1'b0);
    step();
    check1("rmr_valid_rst1", obs_valid[0], 1'b0);
    rst = 1'b0;
    step();
    check1("rmr_valid_post0", obs_valid[0], 1'b0);
    step();
    check1("rmr_valid_post1", obs_valid[0], 1'b0);
    drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h2C, 32'h0);
    step();
    check1("rmr_wait0", obs_wait[0], 1'b0);
    check1("rmr_wait1", obs_wait[1], 1'b1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle_all();
    repeat (3) step();

    // Randomized traffic: masters hold stalled requests, occasional reset.
    busy[0] = 1'b0; busy[1] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!busy[p]) begin
          int k;
          k = int'($urandom_range(0, 9));
          prd[p] = (k >= 3 && k < 6) || (k == 9);
          pwr[p] = (k >= 6);
          pad[p] = $urandom;
          pdt[p] = $urandom;
          busy[p] = (k >= 3);
        end
        drive(p, prd[p], pwr[p], pad[p], pdt[p]);
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
      for (int p = 0; p < 2; p++) if (!obs_wait[p]) busy[p] = 1'b0;
    end
    rst = 1'b0;
    idle_all();
    repeat (4) step();
    checki("drain_m0", pq0.size(), 0);
    checki("drain_m1", pq1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded bound", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
